fft_bfly_r2_stage: RTL and testbench
====================================

// Module: fft_bfly_r2_stage
// PURPOSE
//  Parametrised radix-2 DIF butterfly stage for the 16-lane streaming FFT; generalises fixed stages mod0_0/mod0_1.
//  Each frame: first DEPTH input beats are buffered, next DEPTH beats pair lane-wise with them -> sum and difference.
//  Optional trivial twiddle (-j) on the sub path; emits a one-beat alert to start the next stage/CBFP.
//  Sits between two pipeline stages; chains by alert_out -> next stage's din_valid timing reference.
// PARAMETERS
//  IN_W     9   input sample width (signed, per re/im)
//  LANES    16  parallel complex samples per beat
//  DEPTH    16  beats between butterfly partners (N/2/LANES); power of 2, >=1
//  SUB_ROT  0   1: multiply sub-path output by -j on beats whose in-half index >= DEPTH/2
// PORTS
//  clk          in   1               clock
//  rstn         in   1               synchronous reset, active-low
//  din_valid    in   1               input beat valid
//  din_re       in   IN_W x LANES    signed real
//  din_im       in   IN_W x LANES    signed imag
//  dout_valid   out  1               add/sub outputs valid
//  dout_re_add  out  (IN_W+1)xLANES  re(buf + x)
//  dout_im_add  out  (IN_W+1)xLANES  im(buf + x)
//  dout_re_sub  out  (IN_W+1)xLANES  re(buf - x), optionally rotated
//  dout_im_sub  out  (IN_W+1)xLANES  im(buf - x), optionally rotated
//  alert_out    out  1               1-beat pulse with first output beat of each frame
//  frame_done   out  1               1-beat pulse with last output beat of each frame
// BEHAVIOUR
//  Reset: rstn sampled at posedge clk; all outputs 0, beat counter 0; buffer contents don't-care.
//  Beat counter cnt in [0, 2*DEPTH): advances only on din_valid; wraps 2*DEPTH-1 -> 0. Valid low = stall, cnt holds.
//  cnt < DEPTH (fill half): write din into buffer slot cnt; no output (dout_valid=0).
//  cnt >= DEPTH (compute half): k = cnt-DEPTH; a = buf[k], b = din; add = a+b, sub = a-b, sign-extended to IN_W+1.
//  SUB_ROT=1 and k >= DEPTH/2 (DEPTH>=2): sub := (im, -re) i.e. x(-j). No overflow possible: |a-b| <= 2^IN_W-1.
//  Latency: outputs registered, 1 clk after the compute-half input beat; dout_valid = registered (din_valid & cnt>=DEPTH).
//  alert_out = registered (din_valid & cnt==DEPTH); frame_done = registered (din_valid & cnt==2*DEPTH-1).
//  DEPTH=1: alternate beats fill/compute; alert_out and frame_done assert together.
//  dout_* hold last value when dout_valid=0 (not cleared); only reset clears them.
//  Gapped input: valid gaps anywhere (either half) simply delay pairing; results identical to gap-free stream.
//  Reset mid-frame: frame abandoned, next valid beat starts a new fill half (cnt=0); no stale output.
//  din_valid with rstn=0: ignored.
// STRUCTURE
//  fft_pkg: LANES default, cplx_t typedef struct {re,im}, width helper localparams, rotation enum.
//  Sub-module fft_bfly_delay_buf: DEPTH x LANES x 2 x IN_W register file, wr/rd address = cnt[log2 DEPTH-1:0].
//  Top: counter, butterfly adders (generate over LANES), rotation mux, output registers.
// TESTING
//  1 Reset: hold rstn=0 5 clk with din_valid=1 -> all outputs 0, no alert_out.
//  2 DEPTH=16, lane j fill=j, compute=1 -> add=j+1, sub=j-1 for 16 beats; alert_out at first, frame_done at last.
//  3 Extremes IN_W=9: fill=-256, compute=255 -> add=-1, sub=-511; fill=255, compute=-256 -> sub=511, no wrap.
//  4 SUB_ROT=1: buf=(10,3), din=(4,1) -> sub beats k<8 = (6,2); k>=8 = (2,-6); add=(14,4) always.
//  5 Valid gaps: random 30% din_valid drop over 4 frames -> output sequence bit-equal to gap-free golden model.
//  6 Reset asserted at cnt=20 then released -> next 16 valid beats produce no dout_valid; following 16 pair correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the streaming radix-2 FFT stages.
package fft_pkg;

  localparam int LANES_DEF = 16;
  localparam int IN_W_DEF  = 9;

  typedef struct packed {
    logic signed [IN_W_DEF-1:0] re;
    logic signed [IN_W_DEF-1:0] im;
  } cplx_t;

  typedef enum logic {
    ROT_NONE  = 1'b0,
    ROT_NEG_J = 1'b1
  } rot_e;

  // A one-entry buffer still needs a one-bit address port.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(2 * depth);
  endfunction

endpackage

// File: rtl/fft_bfly_delay_buf.sv
// Holds the fill half of a frame until its butterfly partners arrive.
module fft_bfly_delay_buf
  import fft_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = 16,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [AW-1:0]                addr,
  input  logic [LANES-1:0][IN_W-1:0]   wr_re,
  input  logic [LANES-1:0][IN_W-1:0]   wr_im,
  output logic [LANES-1:0][IN_W-1:0]   rd_re,
  output logic [LANES-1:0][IN_W-1:0]   rd_im
);

  logic [LANES-1:0][IN_W-1:0] mem_re [2**AW];
  logic [LANES-1:0][IN_W-1:0] mem_im [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[addr] <= wr_re;
      mem_im[addr] <= wr_im;
    end
  end

  // Asynchronous read: the partner is needed in the same cycle as the compute beat.
  assign rd_re = mem_re[addr];
  assign rd_im = mem_im[addr];

endmodule

// File: rtl/fft_bfly_r2_stage.sv
// Radix-2 DIF butterfly stage: buffers DEPTH beats, pairs them with the next DEPTH beats.
// din_valid qualifies each beat; there is no backpressure, a low din_valid is simply a stall.
module fft_bfly_r2_stage
  import fft_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int DEPTH   = 16,
  parameter int SUB_ROT = 0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        din_valid,
  input  logic [LANES-1:0][IN_W-1:0]  din_re,
  input  logic [LANES-1:0][IN_W-1:0]  din_im,
  output logic                        dout_valid,
  output logic [LANES-1:0][IN_W:0]    dout_re_add,
  output logic [LANES-1:0][IN_W:0]    dout_im_add,
  output logic [LANES-1:0][IN_W:0]    dout_re_sub,
  output logic [LANES-1:0][IN_W:0]    dout_im_sub,
  output logic                        alert_out,
  output logic                        frame_done
);

  localparam int OW = IN_W + 1;
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = addr_w(DEPTH);

  logic [CW-1:0]              cnt;
  logic [AW-1:0]              addr;
  logic                       comp_half;
  logic                       rot_hi;
  logic                       is_first;
  logic                       is_last;
  logic                       fire;
  rot_e                       rot_sel;
  logic [LANES-1:0][IN_W-1:0] buf_re;
  logic [LANES-1:0][IN_W-1:0] buf_im;
  logic [LANES-1:0][OW-1:0]   add_re;
  logic [LANES-1:0][OW-1:0]   add_im;
  logic [LANES-1:0][OW-1:0]   sub_re;
  logic [LANES-1:0][OW-1:0]   sub_im;

  // DEPTH is a power of two, so the top counter bit marks the compute half
  // and the next bit down marks the upper half of the partner index.
  assign comp_half = cnt[CW-1];
  assign is_first  = (cnt == CW'(DEPTH));
  assign is_last   = &cnt;
  assign fire      = din_valid & comp_half;

  generate
    if (DEPTH > 1) begin : g_addr
      assign addr   = cnt[AW-1:0];
      assign rot_hi = cnt[AW-1];
    end else begin : g_addr1
      assign addr   = '0;
      assign rot_hi = 1'b0;
    end
  endgenerate

  assign rot_sel = ((SUB_ROT != 0) && rot_hi) ? ROT_NEG_J : ROT_NONE;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (din_valid) begin
      cnt <= cnt + 1'b1;
    end
  end

  fft_bfly_delay_buf #(
    .IN_W  (IN_W),
    .LANES (LANES),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .wr_en (din_valid & ~comp_half),
    .addr  (addr),
    .wr_re (din_re),
    .wr_im (din_im),
    .rd_re (buf_re),
    .rd_im (buf_im)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [OW-1:0] a_re, a_im, b_re, b_im, d_re, d_im;

    assign a_re = {buf_re[l][IN_W-1], buf_re[l]};
    assign a_im = {buf_im[l][IN_W-1], buf_im[l]};
    assign b_re = {din_re[l][IN_W-1], din_re[l]};
    assign b_im = {din_im[l][IN_W-1], din_im[l]};

    assign add_re[l] = a_re + b_re;
    assign add_im[l] = a_im + b_im;
    assign d_re      = a_re - b_re;
    assign d_im      = a_im - b_im;

    // Multiplying by -j maps (re, im) to (im, -re); |d| <= 2^IN_W-1 so -d_re fits.
    assign sub_re[l] = (rot_sel == ROT_NEG_J) ? d_im  : d_re;
    assign sub_im[l] = (rot_sel == ROT_NEG_J) ? -d_re : d_im;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_valid  <= 1'b0;
      alert_out   <= 1'b0;
      frame_done  <= 1'b0;
      dout_re_add <= '0;
      dout_im_add <= '0;
      dout_re_sub <= '0;
      dout_im_sub <= '0;
    end else begin
      dout_valid <= fire;
      alert_out  <= fire & is_first;
      frame_done <= fire & is_last;
      if (fire) begin
        dout_re_add <= add_re;
        dout_im_add <= add_im;
        dout_re_sub <= sub_re;
        dout_im_sub <= sub_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly_r2_stage.sv
// Directed bench for the radix-2 butterfly stage; a plain and a -j rotating instance share stimulus.
module tb_fft_bfly_r2_stage;

  localparam int IN_W  = 9;
  localparam int LANES = 16;
  localparam int DEPTH = 16;
  localparam int OW    = IN_W + 1;
  localparam int CW    = LANES * OW;

  typedef logic [LANES-1:0][IN_W-1:0] vin_t;
  typedef logic [LANES-1:0][OW-1:0]   vout_t;
  typedef struct packed {
    logic  alert;
    logic  done;
    vout_t add_re;
    vout_t add_im;
    vout_t sub_re;
    vout_t sub_im;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic  clk = 1'b0;
  logic  rstn = 1'b0;
  logic  rstn_rot = 1'b0;
  logic  din_valid = 1'b0;
  vin_t  din_re = '0;
  vin_t  din_im = '0;
  logic  dout_valid, alert_out, frame_done;
  vout_t dout_re_add, dout_im_add, dout_re_sub, dout_im_sub;
  logic  r_valid, r_alert, r_done;
  vout_t r_re_add, r_im_add, r_re_sub, r_im_sub;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] rot_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  vin_t fb_re[DEPTH];
  vin_t fb_im[DEPTH];

  fft_bfly_r2_stage #(.IN_W(IN_W), .LANES(LANES), .DEPTH(DEPTH), .SUB_ROT(0)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .dout_valid(dout_valid), .dout_re_add(dout_re_add), .dout_im_add(dout_im_add),
    .dout_re_sub(dout_re_sub), .dout_im_sub(dout_im_sub),
    .alert_out(alert_out), .frame_done(frame_done)
  );

  fft_bfly_r2_stage #(.IN_W(IN_W), .LANES(LANES), .DEPTH(DEPTH), .SUB_ROT(1)) dut_rot (
    .clk(clk), .rstn(rstn_rot), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .dout_valid(r_valid), .dout_re_add(r_re_add), .dout_im_add(r_im_add),
    .dout_re_sub(r_re_sub), .dout_im_sub(r_im_sub),
    .alert_out(r_alert), .frame_done(r_done)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  function automatic vin_t rand_vec();
    vin_t v;
    for (int l = 0; l < LANES; l++) v[l] = IN_W'($urandom_range(0, 2**IN_W - 1));
    return v;
  endfunction

  task automatic beat(input logic v, input vin_t re, input vin_t im);
    @(negedge clk);
    din_valid = v;
    din_re    = re;
    din_im    = im;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, rand_vec(), rand_vec());
  endtask

  // Golden butterfly without rotation: (a+b, a-b) per lane, sign-extended.
  function automatic exp_t model(input vin_t ar, input vin_t ai, input vin_t br, input vin_t bi,
                                 input logic alert, input logic done);
    exp_t e;
    e.alert = alert;
    e.done  = done;
    for (int l = 0; l < LANES; l++) begin
      int xar, xai, xbr, xbi;
      xar = $signed(ar[l]);
      xai = $signed(ai[l]);
      xbr = $signed(br[l]);
      xbi = $signed(bi[l]);
      e.add_re[l] = OW'(xar + xbr);
      e.add_im[l] = OW'(xai + xbi);
      e.sub_re[l] = OW'(xar - xbr);
      e.sub_im[l] = OW'(xai - xbi);
    end
    return e;
  endfunction

  // Scoreboard: every valid output beat pops one expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) check("main_unexpected_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("main_add_re", dout_re_add, e.add_re);
          check("main_add_im", dout_im_add, e.add_im);
          check("main_sub_re", dout_re_sub, e.sub_re);
          check("main_sub_im", dout_im_sub, e.sub_im);
          check("main_flags", {alert_out, frame_done}, {e.alert, e.done});
        end
      end else begin
        check("main_idle_flags", {alert_out, frame_done}, 2'b00);
      end
      if (r_valid) begin
        if (rot_q.size() == 0) check("rot_unexpected_valid", 1, 0);
        else begin
          e = rot_q.pop_front();
          check("rot_add_re", r_re_add, e.add_re);
          check("rot_add_im", r_im_add, e.add_im);
          check("rot_sub_re", r_re_sub, e.sub_re);
          check("rot_sub_im", r_im_sub, e.sub_im);
          check("rot_flags", {r_alert, r_done}, {e.alert, e.done});
        end
      end else begin
        check("rot_idle_flags", {r_alert, r_done}, 2'b00);
      end
    end
  end

  initial begin : stim
    vin_t re, im;
    exp_t e, er;
    int   frames_done;

    // 1: reset held with din_valid high
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din_re = rand_vec();
      din_im = rand_vec();
    end
    check("rst_valid", dout_valid, 0);
    check("rst_flags", {alert_out, frame_done}, 2'b00);
    check("rst_add_re", dout_re_add, '0);
    check("rst_add_im", dout_im_add, '0);
    check("rst_sub_re", dout_re_sub, '0);
    check("rst_sub_im", dout_im_sub, '0);
    check("rst_rot_valid", r_valid, 0);
    @(negedge clk);
    rstn      = 1'b1;
    din_valid = 1'b0;
    mon_en    = 1'b1;

    // 2: lane j fill=(j,-j), compute=(1,2)
    for (int k = 0; k < DEPTH; k++) begin
      for (int l = 0; l < LANES; l++) begin
        re[l] = IN_W'(l);
        im[l] = IN_W'(-l);
      end
      beat(1'b1, re, im);
    end
    for (int k = 0; k < DEPTH; k++) begin
      for (int l = 0; l < LANES; l++) begin
        re[l] = IN_W'(1);
        im[l] = IN_W'(2);
        e.add_re[l] = OW'(l + 1);
        e.add_im[l] = OW'(2 - l);
        e.sub_re[l] = OW'(l - 1);
        e.sub_im[l] = OW'(-l - 2);
      end
      e.alert = (k == 0);
      e.done  = (k == DEPTH - 1);
      exp_q.push_back(e);
      beat(1'b1, re, im);
    end
    idle(2);

    // 3: extremes, fill=(-256,255) compute=(255,-256)
    for (int k = 0; k < DEPTH; k++) begin
      for (int l = 0; l < LANES; l++) begin
        re[l] = IN_W'(-256);
        im[l] = IN_W'(255);
      end
      beat(1'b1, re, im);
    end
    for (int k = 0; k < DEPTH; k++) begin
      for (int l = 0; l < LANES; l++) begin
        re[l] = IN_W'(255);
        im[l] = IN_W'(-256);
        e.add_re[l] = OW'(-1);
        e.add_im[l] = OW'(-1);
        e.sub_re[l] = OW'(-511);
        e.sub_im[l] = OW'(511);
      end
      e.alert = (k == 0);
      e.done  = (k == DEPTH - 1);
      exp_q.push_back(e);
      beat(1'b1, re, im);
    end
    idle(1);

    // 4: rotation on second instance, buf=(10,3) din=(4,1)
    @(negedge clk);
    rstn_rot  = 1'b1;
    din_valid = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      re[l] = IN_W'(10);
      im[l] = IN_W'(3);
    end
    for (int k = 0; k < DEPTH; k++) beat(1'b1, re, im);
    for (int k = 0; k < DEPTH; k++) begin
      for (int l = 0; l < LANES; l++) begin
        re[l] = IN_W'(4);
        im[l] = IN_W'(1);
        e.add_re[l]  = OW'(14);
        e.add_im[l]  = OW'(4);
        e.sub_re[l]  = OW'(6);
        e.sub_im[l]  = OW'(2);
        er.add_re[l] = OW'(14);
        er.add_im[l] = OW'(4);
        er.sub_re[l] = (k < DEPTH / 2) ? OW'(6) : OW'(2);
        er.sub_im[l] = (k < DEPTH / 2) ? OW'(2) : OW'(-6);
      end
      e.alert  = (k == 0);
      e.done   = (k == DEPTH - 1);
      er.alert = e.alert;
      er.done  = e.done;
      exp_q.push_back(e);
      rot_q.push_back(er);
      beat(1'b1, re, im);
    end
    @(negedge clk);
    rstn_rot  = 1'b0;
    din_valid = 1'b0;
    idle(1);

    // 5: four frames with ~30% valid drops against the golden model
    frames_done = 0;
    while (frames_done < 4) begin
      for (int k = 0; k < 2 * DEPTH; k++) begin
        while ($urandom_range(0, 99) < 30) idle(1);
        re = rand_vec();
        im = rand_vec();
        if (k < DEPTH) begin
          fb_re[k] = re;
          fb_im[k] = im;
        end else begin
          exp_q.push_back(model(fb_re[k-DEPTH], fb_im[k-DEPTH], re, im,
                                k == DEPTH, k == 2 * DEPTH - 1));
        end
        beat(1'b1, re, im);
      end
      frames_done++;
    end
    idle(2);

    // 6: reset at cnt=20, then a fresh frame must start with a fill half
    for (int k = 0; k < DEPTH; k++) begin
      fb_re[k] = rand_vec();
      fb_im[k] = rand_vec();
      beat(1'b1, fb_re[k], fb_im[k]);
    end
    for (int k = 0; k < 4; k++) begin
      re = rand_vec();
      im = rand_vec();
      exp_q.push_back(model(fb_re[k], fb_im[k], re, im, k == 0, 1'b0));
      beat(1'b1, re, im);
    end
    @(negedge clk);
    rstn      = 1'b0;
    din_valid = 1'b1;
    din_re    = rand_vec();
    din_im    = rand_vec();
    @(negedge clk);
    din_re = rand_vec();
    din_im = rand_vec();
    @(negedge clk);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_add_re", dout_re_add, '0);
    check("mid_rst_sub_im", dout_im_sub, '0);
    rstn      = 1'b1;
    din_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      fb_re[k] = rand_vec();
      fb_im[k] = rand_vec();
      beat(1'b1, fb_re[k], fb_im[k]);
    end
    for (int k = 0; k < DEPTH; k++) begin
      re = rand_vec();
      im = rand_vec();
      exp_q.push_back(model(fb_re[k], fb_im[k], re, im, k == 0, k == DEPTH - 1));
      beat(1'b1, re, im);
    end
    idle(3);

    check("main_queue_drained", exp_q.size(), 0);
    check("rot_queue_drained", rot_q.size(), 0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
